wb_master_arbiter: RTL

Two-master Wishbone arbiter that shares the single shared-bus port between the instruction-fetch bus interface (master 0) and the data-access bus interface (master 1). It sits between the two CPU-side bus interfaces and the Wishbone interconnect or slaves. Arbitration is round-robin at transaction granularity. A per-transaction watchdog terminates any cycle that a slave never acknowledges, so a missing slave cannot deadlock the pipeline.

---
 rtl/wb_master_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin at transaction granularity, with a
// per-transaction watchdog that terminates cycles a slave never acknowledges.
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,

  output logic        timeout_o,
  output logic        timeout_master_o
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last;
  logic [CW-1:0]   wd_cnt;

  logic            req0;
  logic            req1;
  logic            granted;
  logic            owner;
  logic            wd_expired;
  logic            done;

  logic            sel_cyc;
  logic            sel_stb;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [SW-1:0]   sel_sel;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign granted = (state == GRANT0) || (state == GRANT1);
  assign owner   = (state == GRANT1);

  // Request fields of whichever master currently owns the bus
  always_comb begin
    sel_cyc  = 1'b0;
    sel_stb  = 1'b0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_sel  = '0;
    if (state == GRANT0) begin
      sel_cyc  = m0_cyc_i;
      sel_stb  = m0_stb_i;
      sel_we   = m0_we_i;
      sel_addr = m0_addr_i;
      sel_data = m0_data_i;
      sel_sel  = m0_sel_i;
    end else if (state == GRANT1) begin
      sel_cyc  = m1_cyc_i;
      sel_stb  = m1_stb_i;
      sel_we   = m1_we_i;
      sel_addr = m1_addr_i;
      sel_data = m1_data_i;
      sel_sel  = m1_sel_i;
    end
  end

  // Watchdog fires in the TIMEOUT-th granted cycle; an abandoned cycle never times out
  assign wd_expired = granted & sel_cyc & ~s_ack_i & (wd_cnt == CW'(TIMEOUT - 1));
  assign done       = granted & (s_ack_i | ~sel_cyc | wd_expired);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = last ? GRANT0 : GRANT1;
        end else if (req1) begin
          state_nxt = GRANT1;
        end else if (req0) begin
          state_nxt = GRANT0;
        end
      end
      GRANT0, GRANT1: begin
        if (done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared-bus and return paths are muxed straight from state for zero added latency
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    m0_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_data_o = '0;
    timeout_o = 1'b0;
    if (granted) begin
      s_cyc_o   = sel_cyc & ~wd_expired;
      s_stb_o   = sel_stb & ~wd_expired;
      s_we_o    = sel_we;
      s_addr_o  = sel_addr;
      s_data_o  = sel_data;
      s_sel_o   = sel_sel;
      timeout_o = wd_expired;
      if (owner) begin
        m1_ack_o  = (s_ack_i & sel_cyc) | wd_expired;
        m1_data_o = wd_expired ? '0 : s_data_i;
      end else begin
        m0_ack_o  = (s_ack_i & sel_cyc) | wd_expired;
        m0_data_o = wd_expired ? '0 : s_data_i;
      end
    end
  end

  // Round-robin history, watchdog count and sticky timeout source
  always_ff @(posedge clk) begin
    if (rst) begin
      last             <= 1'b0;
      wd_cnt           <= '0;
      timeout_master_o <= 1'b0;
    end else begin
      if ((state == IDLE) && (state_nxt != IDLE)) begin
        last   <= (state_nxt == GRANT1);
        wd_cnt <= '0;
      end else if (granted && !done && (wd_cnt != '1)) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
      if (wd_expired) begin
        timeout_master_o <= owner;
      end
    end
  end

endmodule
